// File: rtl/awaiba_spi_pkg.sv
// -----------------------------------------------------------------------------
// awaiba_spi_pkg
// Shared constants, the responder FSM state type and a counter helper for the
// Awaiba SPI responder (awaiba_spi_slave).
// -----------------------------------------------------------------------------
package awaiba_spi_pkg;

    // Address byte that turns a frame into a read request.
    localparam logic [7:0] READ_CMD_ADDR      = 8'd15;

    // sclk periods the master holds cs_n low for each frame type.
    localparam int         WR_FRAME_LEN       = 19;
    localparam int         RD_FRAME_LEN       = 28;

    // Read bit j is driven after sclk fall RD_DATA_FIRST_FALL + j.
    localparam int         RD_DATA_FIRST_FALL = 20;

    // Command word width: address byte plus data byte.
    localparam int         CMD_BITS           = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        READ,
        COMMIT,
        DONE_RD,
        SKIP
    } spi_state_e;

    // 5-bit increment that stops at 31.
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input with single-clk rise and
// fall pulses derived from the synchronised level.
//
// Ports:
//   clk      system clock
//   res      synchronous active-high reset (chain and edge history clear to 0)
//   d_i      asynchronous input
//   level_o  synchronised level (STAGES clk behind d_i)
//   rise_o   one-clk pulse on a 0->1 change of level_o
//   fall_o   one-clk pulse on a 1->0 change of level_o
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, which is what makes
    // the chain a shift register rather than a single flop.
    always_ff @(posedge clk) begin
        if (res) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/awaiba_spi_slave.sv
// -----------------------------------------------------------------------------
// awaiba_spi_slave
// Sensor-side responder for the Awaiba SPI register protocol. Oversamples
// sclk/cs_n/mosi in the system clock domain, decodes 16-bit LSB-first frames
// (d[7:0] data, d[15:8] address) into a local register file and answers read
// frames (address 15) on miso.
//
// Build option:
//   AWAIBA_SPI_FRAME_ERR_EN  when defined, err_cnt counts malformed frames;
//                            otherwise err_cnt is tied to 0.
//
// Ports:
//   clk          system clock (>= 8x sclk)
//   res          synchronous active-high reset
//   sclk         SPI clock, idles low
//   cs_n         SPI chip select, active low
//   mosi         master data, valid on sclk rise
//   spi_abn_cdp  sensor-pair select, sampled at cs_n fall
//   miso         read data, changes after sclk fall
//   reg_q        flat register file, register i at reg_q[8i+7:8i]
//   wr_stb       one-clk pulse per register write
//   wr_addr      address of the last write
//   wr_data      data of the last write
//   rd_stb       one-clk pulse when a read frame completes
//   err_cnt      saturating frame error count (0 unless the option is on)
// -----------------------------------------------------------------------------
module awaiba_spi_slave
    import awaiba_spi_pkg::*;
#(
    parameter int REG_NUM     = 15,
    parameter bit SENSOR_SEL  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    input  logic                 spi_abn_cdp,
    output logic                 miso,
    output logic [8*REG_NUM-1:0] reg_q,
    output logic                 wr_stb,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 rd_stb,
    output logic [7:0]           err_cnt
);

    localparam int ADDR_W = 4;

    // ---------------------------------------------------------------- inputs
    logic rise_s, fall_s;
    logic cs_lvl, cs_fall, cs_rise;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .res    (res),
        .d_i    (sclk),
        .level_o(),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk    (clk),
        .res    (res),
        .d_i    (cs_n),
        .level_o(cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk    (clk),
        .res    (res),
        .d_i    (mosi),
        .level_o(mosi_s),
        .rise_o (),
        .fall_o ()
    );

    // ----------------------------------------------------------------- state
    spi_state_e  state_q, state_d;
    logic [4:0]  rc_q, rc_d;          // sclk rises in this frame
    logic [4:0]  fc_q, fc_d;          // sclk falls in this frame
    logic [15:0] sr_q, sr_d;          // command shift register
    logic        miso_q, miso_d;
    logic        armed_q;
    logic        wr_en;
    logic        rd_stb_d;
    logic        wr_stb_q;
    logic        rd_stb_q;
    logic [7:0]  wr_addr_q, wr_data_q;
    logic [7:0]  regs_q [REG_NUM];

    logic [7:0]  rd_val;
    logic [4:0]  fc_inc;

    // NOTE: every variable written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        fc_d     = fc_q;
        sr_d     = sr_q;
        miso_d   = miso_q;
        wr_en    = 1'b0;
        rd_stb_d = 1'b0;
        fc_inc   = sat_inc5(fc_q);

        // Out-of-range read addresses answer 0.
        rd_val = 8'h00;
        if (sr_q[7:0] < 8'(REG_NUM)) begin
            rd_val = regs_q[sr_q[ADDR_W-1:0]];
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall && armed_q) begin
                    if (spi_abn_cdp == SENSOR_SEL) begin
                        state_d = SHIFT;
                        rc_d    = 5'd0;
                        fc_d    = 5'd0;
                        sr_d    = 16'h0000;
                    end else begin
                        state_d = SKIP;
                    end
                end
            end

            SHIFT: begin
                // cs_rise outranks a coincident sclk fall.
                if (cs_rise) begin
                    state_d = COMMIT;
                end else if (rc_q == 5'(CMD_BITS) && sr_q[15:8] == READ_CMD_ADDR) begin
                    // Full command seen one clk ago; sclk events are >= 4 clk apart.
                    state_d = READ;
                end else begin
                    if (rise_s) begin
                        if (rc_q < 5'(CMD_BITS)) begin
                            sr_d = {mosi_s, sr_q[15:1]};
                        end
                        rc_d = sat_inc5(rc_q);
                    end
                    if (fall_s) begin
                        fc_d = fc_inc;
                    end
                end
            end

            READ: begin
                if (cs_rise) begin
                    state_d = DONE_RD;
                end else begin
                    if (rise_s) begin
                        rc_d = sat_inc5(rc_q);
                    end
                    if (fall_s) begin
                        fc_d   = fc_inc;
                        miso_d = 1'b0;
                        if (fc_inc >= 5'(RD_DATA_FIRST_FALL) &&
                            fc_inc <= 5'(RD_DATA_FIRST_FALL + 7)) begin
                            miso_d = rd_val[3'(fc_inc - 5'(RD_DATA_FIRST_FALL))];
                        end
                    end
                end
            end

            COMMIT: begin
                miso_d  = 1'b0;
                state_d = IDLE;
                if (rc_q >= 5'(CMD_BITS) && sr_q[15:8] < 8'(REG_NUM) &&
                    sr_q[15:8] != READ_CMD_ADDR) begin
                    wr_en = 1'b1;
                end
            end

            DONE_RD: begin
                miso_d   = 1'b0;
                rd_stb_d = 1'b1;
                state_d  = IDLE;
            end

            SKIP: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            rc_q      <= 5'd0;
            fc_q      <= 5'd0;
            sr_q      <= 16'h0000;
            miso_q    <= 1'b0;
            armed_q   <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
            fc_q     <= fc_d;
            sr_q     <= sr_d;
            miso_q   <= miso_d;
            // A frame already in progress at reset release is discarded.
            armed_q  <= armed_q | cs_lvl;
            wr_stb_q <= wr_en;
            rd_stb_q <= rd_stb_d;
            if (wr_en) begin
                wr_addr_q <= sr_q[15:8];
                wr_data_q <= sr_q[7:0];
            end
        end
    end

    // NOTE: the register file is reset explicitly because it is observable on
    // reg_q and must read back as zero; this keeps it in flops, not RAM.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[sr_q[8 +: ADDR_W]] <= sr_q[7:0];
        end
    end

    // --------------------------------------------------------------- outputs
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_flat
        assign reg_q[8*gi +: 8] = regs_q[gi];
    end

    assign miso    = miso_q;
    assign wr_stb  = wr_stb_q;
    assign rd_stb  = rd_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef AWAIBA_SPI_FRAME_ERR_EN
    logic       err_event;
    logic [7:0] err_cnt_q;

    // Truncated commands, short read frames, and a stray cs_n rise in IDLE.
    always_comb begin
        err_event = 1'b0;
        if (state_q == COMMIT && rc_q < 5'(CMD_BITS)) begin
            err_event = 1'b1;
        end
        if (state_q == DONE_RD &&
            (rc_q < 5'(CMD_BITS) || fc_q < 5'(RD_FRAME_LEN - 1))) begin
            err_event = 1'b1;
        end
        if (state_q == IDLE && cs_rise && armed_q) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            err_cnt_q <= 8'h00;
        end else if (err_event && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_awaiba_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_awaiba_spi_slave
// Directed and randomised frames driven by a behavioural SPI master, checked
// against a frame-level register model. Honours AWAIBA_SPI_FRAME_ERR_EN for
// the expected err_cnt.
// -----------------------------------------------------------------------------
module tb_awaiba_spi_slave;
    import awaiba_spi_pkg::*;

    localparam int REG_NUM    = 15;
    localparam bit SENSOR_SEL = 1'b0;
    localparam int HALF       = 8;      // clk per sclk half period (16x oversampling)
`ifdef AWAIBA_SPI_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic res, sclk, cs_n, mosi, spi_abn_cdp;
    logic                 miso;
    logic [8*REG_NUM-1:0] reg_q;
    logic                 wr_stb, rd_stb;
    logic [7:0]           wr_addr, wr_data, err_cnt;

    awaiba_spi_slave #(
        .REG_NUM    (REG_NUM),
        .SENSOR_SEL (SENSOR_SEL),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .res        (res),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .spi_abn_cdp(spi_abn_cdp),
        .miso       (miso),
        .reg_q      (reg_q),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_stb     (rd_stb),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Strobe high-cycle counters (a stuck strobe shows up as extra counts).
    int wr_pulses = 0;
    int rd_pulses = 0;
    always @(posedge clk) begin
        if (wr_stb === 1'b1) wr_pulses <= wr_pulses + 1;
        if (rd_stb === 1'b1) rd_pulses <= rd_pulses + 1;
    end

    // ----------------------------------------------------------------- model
    logic [7:0] m_regs [REG_NUM];
    int         exp_wr, exp_rd, exp_err;
    logic [7:0] exp_waddr, exp_wdata, exp_cap;
    bit         exp_full_read;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) m_regs[i] = 8'h00;
        exp_waddr = 8'h00;
        exp_wdata = 8'h00;
        exp_err   = 0;
    endtask

    // Effect of one frame of n sclk periods; cs_n rises with the last fall.
    task automatic model_frame(input logic [15:0] word, input int n, input logic sel);
        logic [7:0] addr, data;
        addr          = word[15:8];
        data          = word[7:0];
        exp_full_read = 1'b0;
        if (sel != SENSOR_SEL) return;
        if (n < CMD_BITS) begin
            exp_err++;
        end else if (addr == READ_CMD_ADDR) begin
            exp_rd++;
            exp_cap = (data < REG_NUM) ? m_regs[data] : 8'h00;
            // The last fall is hidden by cs_rise, so a full read needs 28 periods.
            if (n < RD_FRAME_LEN) exp_err++;
            else                  exp_full_read = 1'b1;
        end else if (addr < REG_NUM) begin
            m_regs[addr] = data;
            exp_wr++;
            exp_waddr = addr;
            exp_wdata = data;
        end
    endtask

    // ---------------------------------------------------------------- master
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] word, input int n, input logic sel,
                             input int rst_at, output logic [7:0] cap,
                             output logic outside_bad);
        cap         = 8'h00;
        outside_bad = 1'b0;
        @(negedge clk);
        spi_abn_cdp = sel;
        cs_n        = 1'b0;
        sclk        = 1'b0;
        mosi        = word[0];
        wait_clk(HALF);
        for (int k = 1; k <= n; k++) begin
            sclk = 1'b1;
            if (k == rst_at) begin
                res = 1'b1;
                wait_clk(2);
                res = 1'b0;
                wait_clk(HALF - 2);
            end else begin
                wait_clk(HALF);
            end
            // Value the master captures on fall k.
            if (k >= 21 && k <= 28) cap[k-21] = miso;
            else if (miso !== 1'b0) outside_bad = 1'b1;
            sclk = 1'b0;
            mosi = (k < CMD_BITS) ? word[k] : 1'b0;
            if (k == n) cs_n = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(2 * HALF);
    endtask

    task automatic check_state(input string tag);
        logic [127:0] flat;
        flat = '0;
        for (int i = 0; i < REG_NUM; i++) flat[8*i +: 8] = m_regs[i];
        check({tag, "/reg_q"},   128'(reg_q),     flat);
        check({tag, "/wr_cnt"},  128'(wr_pulses), 128'(exp_wr));
        check({tag, "/rd_cnt"},  128'(rd_pulses), 128'(exp_rd));
        check({tag, "/wr_addr"}, 128'(wr_addr),   128'(exp_waddr));
        check({tag, "/wr_data"}, 128'(wr_data),   128'(exp_wdata));
        check({tag, "/miso"},    128'(miso),      128'(0));
        check({tag, "/err_cnt"}, 128'(err_cnt),   ERR_EN ? 128'(exp_err) : 128'(0));
    endtask

    task automatic do_frame(input string tag, input logic [15:0] word, input int n,
                            input logic sel);
        logic [7:0] cap;
        logic       bad;
        spi_frame(word, n, sel, 0, cap, bad);
        model_frame(word, n, sel);
        check_state(tag);
        check({tag, "/miso_outside"}, 128'(bad), 128'(0));
        if (exp_full_read) check({tag, "/rd_data"}, 128'(cap), 128'(exp_cap));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cap;
        logic       bad;
        int         kind;
        logic [7:0] a;

        res = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; spi_abn_cdp = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_cap = 8'h00; exp_full_read = 1'b0;
        model_reset();
        wait_clk(4);
        check_state("reset");
        check("reset/wr_stb", 128'(wr_stb), 128'(0));
        check("reset/rd_stb", 128'(rd_stb), 128'(0));
        res = 1'b0;
        wait_clk(6);

        // Basic write.
        do_frame("wr_a5", 16'h03A5, WR_FRAME_LEN, 1'b0);
        check("wr_a5/reg3", 128'(reg_q[31:24]), 128'(8'hA5));

        // Write then read back.
        do_frame("wr_5c", 16'h035C, WR_FRAME_LEN, 1'b0);
        do_frame("rd_3",  16'h0F03, RD_FRAME_LEN, 1'b0);

        // Never-written register and an out-of-range write.
        do_frame("rd_14", 16'h0F0E, RD_FRAME_LEN, 1'b0);
        do_frame("wr_20", 16'h1499, WR_FRAME_LEN, 1'b0);

        // Other sensor pair.
        do_frame("skip",  16'h0211, WR_FRAME_LEN, 1'b1);
        check("skip/reg2", 128'(reg_q[23:16]), 128'(8'h00));

        // Reset in the middle of a write with cs_n still low.
        spi_frame(16'h0455, WR_FRAME_LEN, 1'b0, 8, cap, bad);
        model_reset();
        check_state("rst_mid");
        do_frame("wr_77", 16'h0177, WR_FRAME_LEN, 1'b0);
        check("wr_77/reg1", 128'(reg_q[15:8]), 128'(8'h77));

        // Truncated frame and a short read frame.
        do_frame("trunc",   16'h0233, 10, 1'b0);
        do_frame("rd_short", 16'h0F05, 20, 1'b0);
        check("err/two", 128'(err_cnt), ERR_EN ? 128'(2) : 128'(0));

        // Randomised frames.
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 9));
            a    = 8'($urandom_range(0, REG_NUM - 1));
            case (kind)
                0, 1, 2, 3: do_frame("rnd_wr", {a, 8'($urandom)}, WR_FRAME_LEN, 1'b0);
                4, 5:       do_frame("rnd_rd", {8'h0F, 8'($urandom_range(0, 17))},
                                     RD_FRAME_LEN, 1'b0);
                6:          do_frame("rnd_bad_addr", {8'($urandom_range(16, 60)), 8'($urandom)},
                                     WR_FRAME_LEN, 1'b0);
                7:          do_frame("rnd_rd_wrlen", {8'h0F, a}, WR_FRAME_LEN, 1'b0);
                8:          do_frame("rnd_skip", {a, 8'($urandom)}, RD_FRAME_LEN, 1'b1);
                default:    do_frame("rnd_trunc", {a, 8'($urandom)},
                                     int'($urandom_range(3, 15)), 1'b0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/awaiba_spi_slave.md
Name: awaiba_spi_slave

Overview:
- SPI responder for the Awaiba sensor register protocol. It is the sensor-side end of the existing Awaiba SPI master link.
- Runs in the system clock domain and oversamples sclk, cs_n and mosi. It decodes 16-bit LSB-first frames (d[7:0] data, d[15:8] register address) into a local register file.
- Answers read frames (address 15) on miso.
- Used as a sensor emulator for board bring-up without a camera head, and as a loopback target in the master's testbench.

Parameters:
- REG_NUM, 15: number of writable 8-bit registers, addresses 0..REG_NUM-1 (max 15).
- SENSOR_SEL, 0: spi_abn_cdp value this instance answers to (0 = a,b; 1 = c,d).
- SYNC_STAGES, 2: synchroniser depth on sclk, cs_n and mosi (min 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- res  in  1  reset, synchronous, active-high.
- sclk  in  1  SPI clock from the master; idles low and toggles only while cs_n is low.
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  master data; valid on sclk rise.
- spi_abn_cdp  in  1  sensor-pair select from the master.
- miso  out  1  read data; changes after sclk fall.
- reg_q  out  8*REG_NUM  flat register file; register i is reg_q[8i+7:8i].
- wr_stb  out  1  one-clk pulse when a register is written.
- wr_addr  out  8  address of the last write.
- wr_data  out  8  data of the last write.
- rd_stb  out  1  one-clk pulse when a read frame completes.
- err_cnt  out  8  frame error count; see Optional Feature.

Behaviour:
- Reset values: all registers, miso, wr_stb, rd_stb and err_cnt are 0; wr_addr and wr_data are 0; FSM is in IDLE; armed is 0.
- All state changes happen on clk rise only.
- Inputs pass through SYNC_STAGES flops. Edge detectors produce rise_s and fall_s (sclk) and cs_fall and cs_rise (cs_n). Added latency is SYNC_STAGES+1 clk.
- Arming: after reset, frames are ignored until cs_n has been seen high for at least 1 clk. This means reset during a frame discards the rest of that frame.
- Frame selection: spi_abn_cdp is sampled at cs_fall. If it differs from SENSOR_SEL the frame is ignored: FSM goes to SKIP, miso stays 0 and no strobes fire.
- FSM states:
  - IDLE: cs_fall with armed set and select matching -> SHIFT; rise count rc=0, fall count fc=0, sr=0.
  - SHIFT: on rise_s with rc<16, sr <= {mosi_s, sr[15:1]} (LSB first) and rc++. Rises beyond 16 are counted (saturating at 31) but not shifted. On fall_s, fc++ (saturating). When rc reaches 16: sr[15:8]==15 -> READ, otherwise stay in SHIFT until cs_rise. On cs_rise -> COMMIT.
  - READ: holds rdval = register sr[7:0], or 0 if sr[7:0] >= REG_NUM. After the fall_s that brings fc to n (n=20..27), miso <= rdval[n-20]. Outside that window miso=0. cs_rise -> DONE_RD.
  - COMMIT (1 clk): if rc>=16, address < REG_NUM and address != 15, write the register. wr_addr and wr_data are updated and wr_stb=1. Address >= REG_NUM or address 15 with rc>=16 is silently dropped. rc<16 is an error frame with no write. -> IDLE.
  - DONE_RD (1 clk): rd_stb=1, miso=0. Error if rc<16 or fc<27. -> IDLE.
  - SKIP: wait for cs_rise -> IDLE.
- Frame timing driven by the master:
  - Write frames hold cs_n low for 19 sclk periods.
  - Read frames hold cs_n low for 28 sclk periods. The master samples miso on falls 21..28 into bits 0..7, so bit j is driven after fall 20+j.
  - Fall 28 coincides with cs rise and is not relied on.
- Simultaneous events: when cs_rise and fall_s occur in the same clk, cs_rise wins.
- A write to register sr[7:0] in the same clk as a read latch cannot occur, because frames are serial.
- Register 15 (the read-command address) is never stored.

Optional Feature:
- Macro AWAIBA_SPI_FRAME_ERR_EN.
- Defined: err_cnt increments by 1 (saturating at 255) on every error frame defined above, and on cs_rise seen in IDLE while armed.
- Not defined: err_cnt is tied to 0 and the counter logic is removed. All other behaviour is identical.

Decomposition:
- Package awaiba_spi_pkg holds:
  - READ_CMD_ADDR = 8'd15
  - WR_FRAME_LEN = 19
  - RD_FRAME_LEN = 28
  - RD_DATA_FIRST_FALL = 20
  - CMD_BITS = 16
  - the FSM state enum (IDLE, SHIFT, READ, COMMIT, DONE_RD, SKIP)
- One sub-module, spi_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated 3x (sclk, cs_n, mosi; the mosi instance uses only the level output).

Test Plan:
- Write frame, address 3, data 8'hA5 (word 16'h03A5, LSB first, 19 sclk) -> reg_q[31:24]=8'hA5, one wr_stb pulse, wr_addr=3, wr_data=8'hA5.
- Write address 3 = 8'h5C, then read frame 16'h0F03 (28 sclk) -> master captures 8'h5C, one rd_stb pulse, miso=0 outside falls 20..27.
- Read of address 14 after reset -> returns 8'h00. Write to address 20 -> no wr_stb, reg_q unchanged.
- spi_abn_cdp=1 with SENSOR_SEL=0, write 16'h0211 -> register 2 stays 0, miso stays 0, no strobes.
- Reset asserted at sclk 8 of a write, then released with cs_n still low -> no write; the next full frame 16'h0177 writes register 1 = 8'h77.
- With AWAIBA_SPI_FRAME_ERR_EN: a 10-bit truncated frame followed by a 20-fall read frame -> err_cnt=2. Without the macro -> err_cnt=0.
